datapath_ctrl: RTL and testbench

//   Command-side master for the arithmetic datapath (A,B,opcode -> Y,co).

---
 rtl/datapath_ctrl_pkg.sv | 29 ++
 rtl/datapath_ctrl.sv | 122 ++++++++++++
 tb/tb_datapath_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath command controller: opcode map,
// FSM state encoding and the carry-sticky update helper.
package datapath_ctrl_pkg;

    // Datapath opcode map, bit order {zero_b, inv_b, cin}; Y = A + mux(B) + cin
    localparam logic [2:0] OP_ADD    = 3'b000;  // A + B
    localparam logic [2:0] OP_ADD1   = 3'b001;  // A + B + 1
    localparam logic [2:0] OP_ADDNB  = 3'b010;  // A + ~B
    localparam logic [2:0] OP_SUB    = 3'b011;  // A - B
    localparam logic [2:0] OP_PASSA  = 3'b100;  // A
    localparam logic [2:0] OP_INC    = 3'b101;  // A + 1
    localparam logic [2:0] OP_DEC    = 3'b110;  // A - 1
    localparam logic [2:0] OP_PASS   = 3'b111;  // A (carry set)

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Sticky carry on a capture: a simultaneous clear drops the history but
    // the carry being captured still counts.
    function automatic logic sticky_next(input logic sticky,
                                         input logic clr,
                                         input logic co);
        return (clr ? 1'b0 : sticky) | co;
    endfunction

endpackage

// File: rtl/datapath_ctrl.sv
// Command-side master for the arithmetic datapath. Accepts one command at a
// time, drives registered operands/opcode, waits out the datapath latency,
// captures Y/co and returns them on a valid/ready response channel. Keeps an
// accumulator so chained operations need no host round-trip.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int N    = 16,
    parameter int PIPE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_src_acc,
    input  logic         cmd_wr_acc,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         acc_clr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_y,
    output logic         rsp_co,
    output logic         co_sticky,
    output logic [N-1:0] acc,
    output logic [N-1:0] dp_a,
    output logic [N-1:0] dp_b,
    output logic [2:0]   dp_opcode,
    input  logic [N-1:0] dp_y,
    input  logic         dp_co
);

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic        wr_acc_r;
    logic        capture_s;

    // Result is sampled on the last EXEC cycle, when the latency count is spent
    assign capture_s = (state_r == ST_EXEC) && (cnt_r == 2'd0);

    // Command FSM: operand latch, latency countdown and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 2'd0;
            wr_acc_r  <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_co    <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_opcode <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // A clear in the accept cycle means A sees the cleared value
                        dp_a      <= cmd_src_acc ? (acc_clr ? '0 : acc) : cmd_a;
                        dp_b      <= cmd_b;
                        dp_opcode <= cmd_op;
                        wr_acc_r  <= cmd_wr_acc;
                        cnt_r     <= 2'(PIPE);
                        cmd_ready <= 1'b0;
                        state_r   <= ST_EXEC;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r != 2'd0) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else begin
                        rsp_y     <= dp_y;
                        rsp_co    <= dp_co;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator and sticky carry: a capture beats a same-cycle clear for acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            co_sticky <= 1'b0;
        end else if (capture_s) begin
            co_sticky <= sticky_next(co_sticky, acc_clr, dp_co);
            if (wr_acc_r) begin
                acc <= dp_y;
            end else if (acc_clr) begin
                acc <= '0;
            end else begin
                acc <= acc;
            end
        end else if (acc_clr) begin
            acc       <= '0;
            co_sticky <= 1'b0;
        end else begin
            acc       <= acc;
            co_sticky <= co_sticky;
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench: two controllers (PIPE=0 and PIPE=1), each paired with a
// behavioural datapath of matching latency, exercised by the same scenarios.
module tb_datapath_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic [2:0]  cmd_op      [2];
    logic        cmd_src_acc [2];
    logic        cmd_wr_acc  [2];
    logic [15:0] cmd_a       [2];
    logic [15:0] cmd_b       [2];
    logic        acc_clr     [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [15:0] rsp_y       [2];
    logic        rsp_co      [2];
    logic        co_sticky   [2];
    logic [15:0] acc         [2];
    logic [15:0] dp_a        [2];
    logic [15:0] dp_b        [2];
    logic [2:0]  dp_opcode   [2];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mb_s;
        logic [16:0] sum_s;
        logic [15:0] y_s;
        logic        co_s;

        always_comb begin
            mb_s = dp_opcode[g][2] ? 16'h0000 : dp_b[g];
            if (dp_opcode[g][1]) mb_s = ~mb_s;
            sum_s = {1'b0, dp_a[g]} + {1'b0, mb_s} + {16'h0000, dp_opcode[g][0]};
        end

        if (g == 0) begin : g_comb
            assign y_s  = sum_s[15:0];
            assign co_s = sum_s[16];
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_s  <= 16'h0000;
                    co_s <= 1'b0;
                end else begin
                    y_s  <= sum_s[15:0];
                    co_s <= sum_s[16];
                end
            end
        end

        datapath_ctrl #(.N(16), .PIPE(g)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_op(cmd_op[g]), .cmd_src_acc(cmd_src_acc[g]),
            .cmd_wr_acc(cmd_wr_acc[g]), .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]),
            .acc_clr(acc_clr[g]), .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]), .rsp_y(rsp_y[g]), .rsp_co(rsp_co[g]),
            .co_sticky(co_sticky[g]), .acc(acc[g]), .dp_a(dp_a[g]),
            .dp_b(dp_b[g]), .dp_opcode(dp_opcode[g]),
            .dp_y(y_s), .dp_co(co_s)
        );
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it through exactly one (accepting) edge
    task automatic start_cmd(input int d, input logic [2:0] op, input logic src,
                             input logic wr, input logic [15:0] a, input logic [15:0] b);
        cmd_op[d] = op; cmd_src_acc[d] = src; cmd_wr_acc[d] = wr;
        cmd_a[d] = a; cmd_b[d] = b; cmd_valid[d] = 1'b1;
        cyc();
        cmd_valid[d] = 1'b0;
    endtask

    // Count edges until rsp_valid, bounded
    task automatic wait_rsp(input int d, output int lat);
        lat = 0;
        while (!rsp_valid[d] && lat < 12) begin
            cyc();
            lat++;
        end
    endtask

    task automatic ack(input int d);
        rsp_ready[d] = 1'b1;
        cyc();
        rsp_ready[d] = 1'b0;
    endtask

    task automatic pulse_clr(input int d);
        acc_clr[d] = 1'b1;
        cyc();
        acc_clr[d] = 1'b0;
    endtask

    task automatic test_reset(input int d);
        int n_bad;
        start_cmd(d, 3'b000, 1'b0, 1'b1, 16'h0005, 16'h0003);
        checks++;
        if (dp_a[d] !== 16'h0005) begin
            errors++; $display("FAIL rst_pre_dp_a p%0d got %h want 0005", d, dp_a[d]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_y[d] !== 16'h0 ||
            rsp_co[d] !== 1'b0 || co_sticky[d] !== 1'b0 || acc[d] !== 16'h0 ||
            dp_a[d] !== 16'h0 || dp_b[d] !== 16'h0 || dp_opcode[d] !== 3'b000) begin
            errors++;
            $display("FAIL rst_state p%0d got rdy=%b vld=%b y=%h co=%b st=%b acc=%h a=%h b=%h op=%b want rdy=1 rest 0",
                     d, cmd_ready[d], rsp_valid[d], rsp_y[d], rsp_co[d], co_sticky[d],
                     acc[d], dp_a[d], dp_b[d], dp_opcode[d]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1) n_bad++;
        end
        checks++;
        if (n_bad != 0) begin
            errors++; $display("FAIL rst_no_rsp p%0d got %0d bad cycles want 0", d, n_bad);
        end
    endtask

    task automatic test_arith(input int d);
        int lat;
        start_cmd(d, 3'b011, 1'b0, 1'b0, 16'h0005, 16'h0003);
        wait_rsp(d, lat);
        checks++;
        if (lat != d + 1) begin
            errors++; $display("FAIL sub_latency p%0d got %0d want %0d", d, lat, d + 1);
        end
        checks++;
        if (rsp_y[d] !== 16'h0002 || rsp_co[d] !== 1'b1) begin
            errors++; $display("FAIL sub_result p%0d got %h/%b want 0002/1", d, rsp_y[d], rsp_co[d]);
        end
        ack(d);
        start_cmd(d, 3'b000, 1'b0, 1'b0, 16'h0005, 16'h0003);
        wait_rsp(d, lat);
        checks++;
        if (lat != d + 1 || rsp_y[d] !== 16'h0008 || rsp_co[d] !== 1'b0) begin
            errors++;
            $display("FAIL add_result p%0d got lat=%0d %h/%b want lat=%0d 0008/0", d, lat, rsp_y[d], rsp_co[d], d + 1);
        end
        ack(d);
    endtask

    task automatic test_acc_chain(input int d);
        int lat;
        logic [15:0] exp_y [3];
        logic        exp_co [3];
        logic [2:0]  ops [3];
        exp_y[0] = 16'h7FFF; exp_y[1] = 16'hFFFE; exp_y[2] = 16'hFFFD;
        exp_co[0] = 1'b0; exp_co[1] = 1'b0; exp_co[2] = 1'b1;
        ops[0] = 3'b000; ops[1] = 3'b000; ops[2] = 3'b110;
        pulse_clr(d);
        for (int i = 0; i < 3; i++) begin
            start_cmd(d, ops[i], 1'b1, 1'b1, 16'hAAAA, 16'h7FFF);
            wait_rsp(d, lat);
            checks++;
            if (rsp_y[d] !== exp_y[i] || rsp_co[d] !== exp_co[i] || acc[d] !== exp_y[i]) begin
                errors++;
                $display("FAIL acc_chain%0d p%0d got y=%h co=%b acc=%h want %h/%b", i, d,
                         rsp_y[d], rsp_co[d], acc[d], exp_y[i], exp_co[i]);
            end
            ack(d);
        end
    endtask

    task automatic test_carry(input int d);
        int lat;
        pulse_clr(d);
        start_cmd(d, 3'b000, 1'b0, 1'b1, 16'h0010, 16'h0005);
        wait_rsp(d, lat);
        ack(d);
        start_cmd(d, 3'b000, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        wait_rsp(d, lat);
        checks++;
        if (rsp_y[d] !== 16'h0000 || rsp_co[d] !== 1'b1 || co_sticky[d] !== 1'b1 || acc[d] !== 16'h0015) begin
            errors++;
            $display("FAIL carry_wrap p%0d got y=%h co=%b st=%b acc=%h want 0000/1/1/0015", d,
                     rsp_y[d], rsp_co[d], co_sticky[d], acc[d]);
        end
        ack(d);
        pulse_clr(d);
        checks++;
        if (acc[d] !== 16'h0000 || co_sticky[d] !== 1'b0) begin
            errors++; $display("FAIL carry_clr p%0d got acc=%h st=%b want 0000/0", d, acc[d], co_sticky[d]);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int lat;
        int n_bad;
        start_cmd(d, 3'b101, 1'b0, 1'b0, 16'h00FF, 16'h0000);
        wait_rsp(d, lat);
        // Second command held valid while the response is back-pressured
        cmd_op[d] = 3'b011; cmd_src_acc[d] = 1'b0; cmd_wr_acc[d] = 1'b0;
        cmd_a[d] = 16'h1000; cmd_b[d] = 16'h0001; cmd_valid[d] = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (rsp_valid[d] !== 1'b1 || rsp_y[d] !== 16'h0100 || rsp_co[d] !== 1'b0 ||
                cmd_ready[d] !== 1'b0 || dp_a[d] !== 16'h00FF) n_bad++;
        end
        checks++;
        if (n_bad != 0) begin
            errors++; $display("FAIL hold_stable p%0d got %0d bad cycles want 0", d, n_bad);
        end
        rsp_ready[d] = 1'b1;
        cyc();
        rsp_ready[d] = 1'b0;
        checks++;
        if (cmd_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || dp_a[d] !== 16'h00FF) begin
            errors++;
            $display("FAIL hold_release p%0d got rdy=%b vld=%b a=%h want 1/0/00ff", d,
                     cmd_ready[d], rsp_valid[d], dp_a[d]);
        end
        cyc();
        cmd_valid[d] = 1'b0;
        wait_rsp(d, lat);
        checks++;
        if (lat != d + 1 || rsp_y[d] !== 16'h0FFF || rsp_co[d] !== 1'b1) begin
            errors++;
            $display("FAIL hold_second p%0d got lat=%0d %h/%b want lat=%0d 0fff/1", d, lat,
                     rsp_y[d], rsp_co[d], d + 1);
        end
        ack(d);
    endtask

    task automatic test_clr_capture(input int d);
        int lat;
        start_cmd(d, 3'b000, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        wait_rsp(d, lat);
        ack(d);
        start_cmd(d, 3'b000, 1'b0, 1'b1, 16'h1234, 16'h0000);
        for (int i = 0; i < d; i++) cyc();
        pulse_clr(d);
        wait_rsp(d, lat);
        checks++;
        if (acc[d] !== 16'h1234 || co_sticky[d] !== 1'b0 || rsp_y[d] !== 16'h1234) begin
            errors++;
            $display("FAIL clr_on_capture p%0d got acc=%h st=%b y=%h want 1234/0/1234", d,
                     acc[d], co_sticky[d], rsp_y[d]);
        end
        ack(d);
        acc_clr[d] = 1'b1;
        start_cmd(d, 3'b000, 1'b1, 1'b0, 16'h5555, 16'h0001);
        acc_clr[d] = 1'b0;
        checks++;
        if (dp_a[d] !== 16'h0000) begin
            errors++; $display("FAIL clr_on_accept p%0d got dp_a=%h want 0000", d, dp_a[d]);
        end
        wait_rsp(d, lat);
        checks++;
        if (rsp_y[d] !== 16'h0001 || acc[d] !== 16'h0000) begin
            errors++; $display("FAIL clr_accept_rsp p%0d got y=%h acc=%h want 0001/0000", d, rsp_y[d], acc[d]);
        end
        ack(d);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = 3'b000; cmd_src_acc[i] = 1'b0;
            cmd_wr_acc[i] = 1'b0; cmd_a[i] = 16'h0; cmd_b[i] = 16'h0;
            acc_clr[i] = 1'b0; rsp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        for (int d = 0; d < 2; d++) begin
            test_reset(d);
            test_arith(d);
            test_acc_chain(d);
            test_carry(d);
            test_back_to_back(d);
            test_clr_capture(d);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
